// File: rtl/rank_rd_data_collector.sv
// ----------------------------------------------------------------------------
// rank_rd_data_collector
//
// Controller-side consumer of one rank's read DQ stream. Beats arriving on
// rankRdData are gathered into a line of BURST_LENGTH beats. Each completed
// line is tagged with the read ID pushed when the RD command was issued; IDs
// are consumed in issue order. Completed lines are buffered and handed to the
// controller through a first-word-fall-through valid/ready interface.
//
// The DQ side cannot be stalled. RD issue is therefore gated by credits: a
// tag may only be pushed while (tags outstanding + lines buffered) < DEPTH,
// so every line that completes is guaranteed a free buffer slot.
//
// Ports
//   clk            clock
//   rst            synchronous, active-high reset
//   tagPushValid   scheduler issues an RD; push tagPushId
//   tagPushReady   credit available; an RD may issue this cycle
//   tagPushId      ID of the issued read
//   rankDQRdValid  beat valid on rankRdData
//   rankRdData     one read beat
//   rdValid        a completed line is available at the head
//   rdReady        consumer accepts the head line
//   rdData         head line, beat 0 in the LSBs (zero while empty)
//   rdTag          tag of the head line (zero while empty)
//   errOrphanBeat  sticky: a beat arrived with no outstanding tag
// ----------------------------------------------------------------------------
module rank_rd_data_collector #(
    parameter int MEM_DATAWIDTH = 64,
    parameter int BURST_LENGTH  = 8,
    parameter int TAG_WIDTH     = 6,
    parameter int DEPTH         = 4
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  tagPushValid,
    output logic                                  tagPushReady,
    input  logic [TAG_WIDTH-1:0]                  tagPushId,
    input  logic                                  rankDQRdValid,
    input  logic [MEM_DATAWIDTH-1:0]              rankRdData,
    output logic                                  rdValid,
    input  logic                                  rdReady,
    output logic [MEM_DATAWIDTH*BURST_LENGTH-1:0] rdData,
    output logic [TAG_WIDTH-1:0]                  rdTag,
    output logic                                  errOrphanBeat
);

    localparam int LINE_W = MEM_DATAWIDTH * BURST_LENGTH;
    localparam int BEAT_W = $clog2(BURST_LENGTH);
    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LENGTH - 1);
    localparam logic [PTR_W-1:0]  LAST_PTR  = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [CNT_W:0]    CREDITS   = (CNT_W + 1)'(DEPTH);

    // Circular-buffer pointer advance; DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] ptr);
        nextPtr = (ptr == LAST_PTR) ? '0 : ptr + 1'b1;
    endfunction

    // Occupancy update by net change of one push and one pop.
    function automatic logic [CNT_W-1:0] nextCount(input logic [CNT_W-1:0] cnt,
                                                    input logic inc,
                                                    input logic dec);
        case ({inc, dec})
            2'b10:   nextCount = cnt + 1'b1;
            2'b01:   nextCount = cnt - 1'b1;
            default: nextCount = cnt;
        endcase
    endfunction

    // Tag queue: IDs of issued reads whose data has not fully arrived.
    logic [TAG_WIDTH-1:0] tagMem [DEPTH];
    logic [PTR_W-1:0]     tagWrPtr;
    logic [PTR_W-1:0]     tagRdPtr;
    logic [CNT_W-1:0]     tagCount;

    // Line buffer: completed lines with their tags, awaiting the consumer.
    logic [LINE_W-1:0]    lineMem    [DEPTH];
    logic [TAG_WIDTH-1:0] lineTagMem [DEPTH];
    logic [PTR_W-1:0]     outWrPtr;
    logic [PTR_W-1:0]     outRdPtr;
    logic [CNT_W-1:0]     outCount;

    // Assembly of the burst currently on the DQ bus.
    logic [LINE_W-1:0]    partLine;
    logic [BEAT_W-1:0]    beatCnt;

    logic [CNT_W:0]       inflight;
    logic                 tagPush;
    logic                 tagAvail;
    logic                 beatTake;
    logic                 beatLast;
    logic                 orphanBeat;
    logic                 linePop;
    logic [LINE_W-1:0]    fullLine;

    // Credit is derived from registered counts only, so a pop this cycle
    // frees its credit in the next cycle.
    assign inflight     = {1'b0, tagCount} + {1'b0, outCount};
    assign tagPushReady = (inflight < CREDITS);
    assign tagPush      = tagPushValid && tagPushReady;

    // A beat is only meaningful while some read is outstanding.
    assign tagAvail   = (tagCount != '0);
    assign beatTake   = rankDQRdValid && tagAvail;
    assign beatLast   = beatTake && (beatCnt == LAST_BEAT);
    assign orphanBeat = rankDQRdValid && !tagAvail;

    assign rdValid = (outCount != '0);
    assign linePop = rdValid && rdReady;
    assign rdData  = rdValid ? lineMem[outRdPtr]    : '0;
    assign rdTag   = rdValid ? lineTagMem[outRdPtr] : '0;

    // The completing beat is merged combinationally so the full line can be
    // written into the buffer on the same edge that captures the last beat.
    always_comb begin
        fullLine = partLine;
        fullLine[LINE_W-1 -: MEM_DATAWIDTH] = rankRdData;
    end

    // Control state: pointers, counts, beat counter, sticky error.
    always_ff @(posedge clk) begin
        if (rst) begin
            tagWrPtr      <= '0;
            tagRdPtr      <= '0;
            tagCount      <= '0;
            outWrPtr      <= '0;
            outRdPtr      <= '0;
            outCount      <= '0;
            beatCnt       <= '0;
            errOrphanBeat <= 1'b0;
        end else begin
            if (tagPush) begin
                tagWrPtr <= nextPtr(tagWrPtr);
            end
            if (beatLast) begin
                tagRdPtr <= nextPtr(tagRdPtr);
                outWrPtr <= nextPtr(outWrPtr);
            end
            if (linePop) begin
                outRdPtr <= nextPtr(outRdPtr);
            end
            tagCount <= nextCount(tagCount, tagPush, beatLast);
            outCount <= nextCount(outCount, beatLast, linePop);
            // beatCnt is a power-of-two counter, so the last beat wraps to 0.
            if (beatTake) begin
                beatCnt <= beatCnt + 1'b1;
            end
            if (orphanBeat) begin
                errOrphanBeat <= 1'b1;
            end
        end
    end

    // Data storage carries no reset: validity is tracked entirely by the
    // control state above, and every slot is rewritten before it is read.
    always_ff @(posedge clk) begin
        if (tagPush) begin
            tagMem[tagWrPtr] <= tagPushId;
        end
        if (beatTake) begin
            partLine[beatCnt*MEM_DATAWIDTH +: MEM_DATAWIDTH] <= rankRdData;
        end
        if (beatLast) begin
            lineMem[outWrPtr]    <= fullLine;
            lineTagMem[outWrPtr] <= tagMem[tagRdPtr];
        end
    end

    // A completing line always has a tag outstanding, which holds a credit,
    // so the line buffer can never be full when a line completes.
    lineBufNoOverflow: assert property (@(posedge clk) disable iff (rst)
        beatLast |-> (outCount != FULL_CNT));

endmodule
